// File: rtl/hermes_switch_control_pkg.sv
// HermesPkg: shared router types, switch-allocator FSM states and the XY
// routing helper used by hermes_switch_control.
package HermesPkg;

    localparam int NPORT           = 5;
    // Widest x or y field the XY helper accepts (flits up to 32 bits).
    localparam int HERMES_HALF_MAX = 16;

    typedef enum logic [2:0] {
        HERMES_EAST  = 3'd0,
        HERMES_WEST  = 3'd1,
        HERMES_NORTH = 3'd2,
        HERMES_SOUTH = 3'd3,
        HERMES_LOCAL = 3'd4
    } hermes_port_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_ROUTE,
        S_GRANT
    } hermes_sw_state_t;

    // Address in normalized form: x zero-extended in the upper half,
    // y zero-extended in the lower half, so one function serves any FLIT_SIZE.
    typedef logic [2*HERMES_HALF_MAX-1:0] hermes_xy_t;

    // Dimension-ordered XY routing: settle x first, then y, else deliver locally.
    function automatic hermes_port_t hermes_xy_route(input hermes_xy_t addr, input hermes_xy_t tgt);
        logic [HERMES_HALF_MAX-1:0] x, y, tx, ty;
        hermes_port_t               p;
        x  = addr[2*HERMES_HALF_MAX-1:HERMES_HALF_MAX];
        y  = addr[HERMES_HALF_MAX-1:0];
        tx = tgt[2*HERMES_HALF_MAX-1:HERMES_HALF_MAX];
        ty = tgt[HERMES_HALF_MAX-1:0];
        if (tx > x)      p = HERMES_EAST;
        else if (tx < x) p = HERMES_WEST;
        else if (ty > y) p = HERMES_NORTH;
        else if (ty < y) p = HERMES_SOUTH;
        else             p = HERMES_LOCAL;
        return p;
    endfunction

endpackage

// File: rtl/hermes_rr_arbiter.sv
// hermes_rr_arbiter: combinational round-robin pick. Searches from the port
// after ptr, wrapping LOCAL->EAST; the caller owns the pointer register.
module hermes_rr_arbiter
    import HermesPkg::*;
(
    input  logic [NPORT-1:0] req,
    input  hermes_port_t     ptr,
    output logic [NPORT-1:0] gnt,
    output hermes_port_t     gnt_idx,
    output logic             gnt_any
);

    int         idx;
    logic [2:0] idx3;

    // First requester strictly after ptr wins; ptr itself is checked last.
    always_comb begin
        gnt     = '0;
        gnt_idx = HERMES_EAST;
        gnt_any = 1'b0;
        idx     = 0;
        idx3    = '0;
        for (int k = 1; k <= NPORT; k++) begin
            idx  = (int'(ptr) + k) % NPORT;
            idx3 = idx[2:0];
            if (!gnt_any && req[idx3]) begin
                gnt_any    = 1'b1;
                gnt[idx3]  = 1'b1;
                gnt_idx    = hermes_port_t'(idx3);
            end
        end
    end

endmodule

// File: rtl/hermes_switch_control.sv
// hermes_switch_control: switch allocator for one Hermes router. Serves one
// header at a time (IDLE->ARB->ROUTE->GRANT) and owns the connection table
// that drives the crossbar muxes.
// Optional feature macro: HERMES_SW_GRANT_CNT_EN adds per-output grant counters.
module hermes_switch_control
    import HermesPkg::*;
#(
    parameter int                   FLIT_SIZE = 16,
    parameter logic [FLIT_SIZE-1:0] ADDRESS   = '0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NPORT-1:0]                    req_i,
    input  logic [NPORT-1:0][FLIT_SIZE-1:0]     header_i,
    input  logic [NPORT-1:0]                    release_i,
    output logic [NPORT-1:0]                    ack_h_o,
    output logic [NPORT-1:0]                    free_o,
    output hermes_port_t [NPORT-1:0]            in_sel_o,
    output hermes_port_t [NPORT-1:0]            out_sel_o,
`ifdef HERMES_SW_GRANT_CNT_EN
    output logic [NPORT-1:0]                    out_en_o,
    output logic [NPORT-1:0][15:0]              grant_cnt_o
`else
    output logic [NPORT-1:0]                    out_en_o
`endif
);

    localparam int HALF = FLIT_SIZE / 2;

    // Zero-extend the x/y halves into the package's fixed-width form.
    function automatic hermes_xy_t to_xy(input logic [FLIT_SIZE-1:0] a);
        hermes_xy_t r;
        r = '0;
        r[HERMES_HALF_MAX +: HALF] = a[HALF +: HALF];
        r[0 +: HALF]               = a[0 +: HALF];
        return r;
    endfunction

    hermes_sw_state_t       state, state_nxt;
    hermes_port_t           rr_ptr, sel, tgt;
    logic [FLIT_SIZE-1:0]   hdr;
    logic                   grant_now;

    logic [NPORT-1:0]       arb_gnt;
    hermes_port_t           arb_idx;
    logic                   arb_any;

    // Inputs that already own an output do not compete again.
    hermes_rr_arbiter u_arb (
        .req     (req_i & ~out_en_o),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state, header ack and grant strobe; GRANT uses the registered free_o.
    always_comb begin
        state_nxt = state;
        ack_h_o   = '0;
        grant_now = 1'b0;
        case (state)
            S_IDLE:  if (|(req_i & ~out_en_o)) state_nxt = S_ARB;
            S_ARB:   state_nxt = arb_any ? S_ROUTE : S_IDLE;
            S_ROUTE: state_nxt = req_i[sel] ? S_GRANT : S_IDLE;
            S_GRANT: begin
                state_nxt = S_IDLE;
                if (free_o[tgt]) begin
                    grant_now    = 1'b1;
                    ack_h_o[sel] = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Arbitration/routing datapath: latch winner and header, then its XY target.
    // The pointer moves on every pick, so a blocked requester yields to others.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= HERMES_LOCAL;
            sel    <= HERMES_EAST;
            tgt    <= HERMES_EAST;
            hdr    <= '0;
        end else begin
            if (state == S_ARB && arb_any) begin
                sel    <= arb_idx;
                rr_ptr <= arb_idx;
                hdr    <= header_i[arb_idx];
            end
            if (state == S_ROUTE) tgt <= hermes_xy_route(to_xy(ADDRESS), to_xy(hdr));
        end
    end

    // Connection table: releases and a grant touch disjoint entries, so both apply together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            free_o   <= '1;
            out_en_o <= '0;
            for (int p = 0; p < NPORT; p++) begin
                in_sel_o[p]  <= HERMES_EAST;
                out_sel_o[p] <= HERMES_EAST;
            end
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                if (release_i[i] && out_en_o[i]) begin
                    free_o[out_sel_o[i]] <= 1'b1;
                    out_en_o[i]          <= 1'b0;
                end
            end
            if (grant_now) begin
                free_o[tgt]    <= 1'b0;
                in_sel_o[tgt]  <= sel;
                out_sel_o[sel] <= tgt;
                out_en_o[sel]  <= 1'b1;
            end
        end
    end

`ifdef HERMES_SW_GRANT_CNT_EN
    // Saturating per-output grant counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_cnt_o <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (grant_now && int'(tgt) == p && grant_cnt_o[p] != 16'hFFFF)
                    grant_cnt_o[p] <= grant_cnt_o[p] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hermes_switch_control.sv
// Scoreboard bench for hermes_switch_control (ADDRESS=16'h0101, FLIT_SIZE=16).
module tb_hermes_switch_control;
    import HermesPkg::*;

    logic                         clk_i = 1'b0;
    logic                         rst_i = 1'b1;
    logic [NPORT-1:0]             req_i = '0;
    logic [NPORT-1:0][15:0]       header_i = '0;
    logic [NPORT-1:0]             release_i = '0;
    logic [NPORT-1:0]             ack_h_o, free_o, out_en_o;
    hermes_port_t [NPORT-1:0]     in_sel_o, out_sel_o;
`ifdef HERMES_SW_GRANT_CNT_EN
    logic [NPORT-1:0][15:0]       grant_cnt_o;
`endif

    hermes_switch_control #(.FLIT_SIZE(16), .ADDRESS(16'h0101)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .header_i  (header_i),
        .release_i (release_i),
        .ack_h_o   (ack_h_o),
        .free_o    (free_o),
        .in_sel_o  (in_sel_o),
        .out_sel_o (out_sel_o),
`ifdef HERMES_SW_GRANT_CNT_EN
        .out_en_o  (out_en_o),
        .grant_cnt_o (grant_cnt_o)
`else
        .out_en_o  (out_en_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct { hermes_port_t src; hermes_port_t dst; } exp_t;
    exp_t sb[$];
    int   ack_cyc[$];
    int   nchk = 0, nfail = 0, cyc = 0;
    logic pend = 1'b0;
    exp_t pe;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Scoreboard monitor: each ack pops one expectation; tables checked the cycle after.
    always @(negedge clk_i) begin
        if (rst_i) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("tbl_in_sel",  in_sel_o[pe.dst],  pe.src);
                chk("tbl_out_sel", out_sel_o[pe.src], pe.dst);
                chk("tbl_out_en",  out_en_o[pe.src],  1);
                chk("tbl_free",    free_o[pe.dst],    0);
                pend = 1'b0;
            end
            if (ack_h_o != '0) begin
                if (sb.size() == 0) begin
                    chk("unexp_ack", ack_h_o, 0);
                end else begin
                    pe = sb.pop_front();
                    chk("ack", ack_h_o, 32'(1) << pe.src);
                    ack_cyc.push_back(cyc);
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic raise(input hermes_port_t p, input logic [15:0] h);
        @(posedge clk_i); #1;
        header_i[p] = h;
        req_i[p]    = 1'b1;
    endtask

    task automatic drop(input hermes_port_t p);
        @(posedge clk_i); #1;
        req_i[p] = 1'b0;
    endtask

    task automatic pulse_rel(input hermes_port_t p);
        @(posedge clk_i); #1;
        release_i[p] = 1'b1;
        @(posedge clk_i); #1;
        release_i[p] = 1'b0;
    endtask

    // Cycle count (1 = cycle req was raised in) until ack on p; 0 if the budget expires.
    task automatic wait_ack(input hermes_port_t p, input int maxc, output int n);
        n = 0;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk_i);
            if (ack_h_o[p]) begin
                n = i;
                break;
            end
        end
        chk("ack_seen", 32'(n != 0), 1);
    endtask

    // Full single-requester transaction: ack, tables, release.
    task automatic route_one(input hermes_port_t src, input logic [15:0] h, input hermes_port_t dst);
        int n;
        sb.push_back('{src, dst});
        raise(src, h);
        wait_ack(src, 20, n);
        chk("latency", n, 4);
        drop(src);
        @(negedge clk_i);
        chk("out_sel", out_sel_o[src], dst);
        pulse_rel(src);
        @(negedge clk_i);
        chk("rel_free", free_o, 5'h1F);
        chk("rel_out_en", out_en_o, 0);
    endtask

    initial begin
        int n, seen, t0;
        hermes_port_t [NPORT-1:0] eo;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_free", free_o, 5'h1F);
        chk("rst_out_en", out_en_o, 0);
        chk("rst_ack", ack_h_o, 0);
        chk("rst_in_sel", in_sel_o, 0);
        chk("rst_out_sel", out_sel_o, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        // LOCAL -> EAST, then release
        sb.push_back('{HERMES_LOCAL, HERMES_EAST});
        raise(HERMES_LOCAL, 16'h0301);
        wait_ack(HERMES_LOCAL, 20, n);
        chk("t2_latency", n, 4);
        drop(HERMES_LOCAL);
        @(negedge clk_i);
        chk("t2_in_sel_east", in_sel_o[HERMES_EAST], HERMES_LOCAL);
        chk("t2_free_east", free_o[HERMES_EAST], 0);
        pulse_rel(HERMES_LOCAL);
        @(negedge clk_i);
        chk("t2_rel_free_east", free_o[HERMES_EAST], 1);

        // Remaining routing directions
        route_one(HERMES_LOCAL, 16'h0001, HERMES_WEST);
        route_one(HERMES_LOCAL, 16'h0105, HERMES_NORTH);
        route_one(HERMES_LOCAL, 16'h0100, HERMES_SOUTH);
        route_one(HERMES_LOCAL, 16'h0101, HERMES_LOCAL);

        // Contention: WEST and NORTH both want SOUTH; WEST first
        sb.push_back('{HERMES_WEST, HERMES_SOUTH});
        @(posedge clk_i); #1;
        header_i[HERMES_WEST]  = 16'h0100;
        header_i[HERMES_NORTH] = 16'h0100;
        req_i[HERMES_WEST]     = 1'b1;
        req_i[HERMES_NORTH]    = 1'b1;
        wait_ack(HERMES_WEST, 20, n);
        chk("t4_west_latency", n, 4);
        drop(HERMES_WEST);
        seen = 0;
        repeat (12) begin
            @(negedge clk_i);
            if (ack_h_o != '0) seen++;
        end
        chk("t4_north_blocked", seen, 0);
        sb.push_back('{HERMES_NORTH, HERMES_SOUTH});
        pulse_rel(HERMES_WEST);
        wait_ack(HERMES_NORTH, 20, n);
        drop(HERMES_NORTH);
        @(negedge clk_i);
        chk("t4_in_sel_south", in_sel_o[HERMES_SOUTH], HERMES_NORTH);
        pulse_rel(HERMES_NORTH);
        @(negedge clk_i);
        chk("t4_free", free_o, 5'h1F);

        // Abort: SOUTH drops req while FSM is in ROUTE
        raise(HERMES_SOUTH, 16'h0201);
        @(posedge clk_i);
        @(posedge clk_i); #1;
        req_i[HERMES_SOUTH] = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (ack_h_o != '0) seen++;
        end
        chk("t5_no_ack", seen, 0);
        chk("t5_free", free_o, 5'h1F);
        chk("t5_out_en", out_en_o, 0);
        route_one(HERMES_LOCAL, 16'h0101, HERMES_LOCAL);

        // Reset mid-run with one connection held and another request in flight
        sb.push_back('{HERMES_EAST, HERMES_WEST});
        raise(HERMES_EAST, 16'h0001);
        wait_ack(HERMES_EAST, 20, n);
        drop(HERMES_EAST);
        sb.push_back('{HERMES_WEST, HERMES_EAST});
        raise(HERMES_WEST, 16'h0201);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        chk("t1_free", free_o, 5'h1F);
        chk("t1_out_en", out_en_o, 0);
        chk("t1_ack", ack_h_o, 0);
        sb.delete();
        req_i = '0;
        @(negedge clk_i);
        chk("t1_ack_hold", ack_h_o, 0);
        chk("t1_out_sel", out_sel_o, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        // All five inputs to distinct outputs: grants EAST..LOCAL, 4 cycles apart
        ack_cyc.delete();
        sb.push_back('{HERMES_EAST,  HERMES_WEST});
        sb.push_back('{HERMES_WEST,  HERMES_EAST});
        sb.push_back('{HERMES_NORTH, HERMES_SOUTH});
        sb.push_back('{HERMES_SOUTH, HERMES_NORTH});
        sb.push_back('{HERMES_LOCAL, HERMES_LOCAL});
        @(posedge clk_i); #1;
        header_i[HERMES_EAST]  = 16'h0001;
        header_i[HERMES_WEST]  = 16'h0201;
        header_i[HERMES_NORTH] = 16'h0100;
        header_i[HERMES_SOUTH] = 16'h0102;
        header_i[HERMES_LOCAL] = 16'h0101;
        req_i = 5'h1F;
        t0 = cyc;
        repeat (24) @(negedge clk_i);
        chk("t6_nacks", ack_cyc.size(), 5);
        chk("t6_sb_empty", sb.size(), 0);
        if (ack_cyc.size() > 0) chk("t6_first", ack_cyc[0] - t0, 3);
        for (int i = 1; i < ack_cyc.size(); i++)
            chk($sformatf("t6_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 4);
        eo[HERMES_EAST]  = HERMES_WEST;
        eo[HERMES_WEST]  = HERMES_EAST;
        eo[HERMES_NORTH] = HERMES_SOUTH;
        eo[HERMES_SOUTH] = HERMES_NORTH;
        eo[HERMES_LOCAL] = HERMES_LOCAL;
        chk("t6_out_sel", out_sel_o, eo);
        chk("t6_in_sel", in_sel_o, eo);
        chk("t6_out_en", out_en_o, 5'h1F);
        chk("t6_free", free_o, 0);
`ifdef HERMES_SW_GRANT_CNT_EN
        for (int p = 0; p < NPORT; p++)
            chk($sformatf("t6_cnt%0d", p), grant_cnt_o[p], 1);
`endif
        req_i = '0;

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
